// File: rtl/reg_file_dump.sv
// reg_file_dump: byte-strobed register file with a back-pressured dump engine.
// Optional write-to-read bypass compiled in with REGFILE_BYPASS_EN.
module reg_file_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [ADDR_WIDTH-1:0]   readReg1,
  input  logic [ADDR_WIDTH-1:0]   readReg2,
  output logic [DATA_WIDTH-1:0]   readData1,
  output logic [DATA_WIDTH-1:0]   readData2,
  input  logic                    regWrite,
  input  logic [ADDR_WIDTH-1:0]   writeReg,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic [DATA_WIDTH/8-1:0] writeStrb,
  input  logic                    dumpStart,
  input  logic                    dumpReady,
  output logic                    dumpValid,
  output logic [ADDR_WIDTH-1:0]   dumpAddr,
  output logic [DATA_WIDTH-1:0]   dumpData,
  output logic                    dumpBusy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] idx_d;
  logic [DATA_WIDTH-1:0] dump_q;
  logic [DATA_WIDTH-1:0] stored1, stored2;
  logic [DATA_WIDTH-1:0] cap_start, cap_next;
  logic                  wr_ok;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_ok     = regWrite && !is_zero(writeReg);
  assign stored1   = is_zero(readReg1) ? '0 : regs_q[readReg1];
  assign stored2   = is_zero(readReg2) ? '0 : regs_q[readReg2];
  assign idx_d     = idx_q + ADDR_WIDTH'(1);
  assign cap_start = is_zero('0) ? '0 : regs_q[0];
  assign cap_next  = is_zero(idx_d) ? '0 : regs_q[idx_d];

`ifdef REGFILE_BYPASS_EN
  logic [DATA_WIDTH-1:0] merge1, merge2;

  // Merge in-flight write bytes over the stored values for forwarding.
  always_comb begin
    merge1 = stored1;
    merge2 = stored2;
    for (int b = 0; b < NB; b++) begin
      if (writeStrb[b]) begin
        merge1[8*b +: 8] = writeData[8*b +: 8];
        merge2[8*b +: 8] = writeData[8*b +: 8];
      end
    end
  end

  assign readData1 = (wr_ok && readReg1 == writeReg) ? merge1 : stored1;
  assign readData2 = (wr_ok && readReg2 == writeReg) ? merge2 : stored2;
`else
  assign readData1 = stored1;
  assign readData2 = stored2;
`endif

  // Storage array: byte-strobed write, register 0 optionally hardwired.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (writeStrb[b]) begin
          regs_q[writeReg][8*b +: 8] <= writeData[8*b +: 8];
        end
      end
    end
  end

  // Dump engine: capture stored (pre-write) value, advance per handshake.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dump_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dumpStart) begin
            state_q <= SEND;
            idx_q   <= '0;
            dump_q  <= cap_start;
          end
        end
        SEND: begin
          if (dumpReady) begin
            if (idx_q == LAST) begin
              state_q <= IDLE;
            end else begin
              idx_q  <= idx_d;
              dump_q <= cap_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dumpValid = (state_q == SEND);
  assign dumpBusy  = (state_q == SEND);
  assign dumpAddr  = idx_q;
  assign dumpData  = dump_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// tb_reg_file_dump: directed bench for reg_file_dump.
// Dump beats are predicted into a queue at start and popped per handshake.
module tb_reg_file_dump;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [4:0]  readReg1, readReg2;
  logic [31:0] readData1, readData2;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [3:0]  writeStrb;
  logic        dumpStart, dumpReady;
  logic        dumpValid, dumpBusy;
  logic [4:0]  dumpAddr;
  logic [31:0] dumpData;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] mdl [32];
  int          errs = 0;
  int          checks = 0;
  int          busy_cnt;
  int          g;

  reg_file_dump dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2),
    .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .writeStrb(writeStrb),
    .dumpStart(dumpStart), .dumpReady(dumpReady),
    .dumpValid(dumpValid), .dumpAddr(dumpAddr),
    .dumpData(dumpData), .dumpBusy(dumpBusy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    regWrite  = 1'b1;
    writeReg  = a;
    writeData = d;
    writeStrb = s;
    tick();
    regWrite  = 1'b0;
    if (a != 5'd0) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic push_dump();
    beat_t e;
    for (int r = 0; r < 32; r++) begin
      e.addr = 5'(r);
      e.data = mdl[r];
      sb.push_back(e);
    end
  endtask

  task automatic dump_step();
    beat_t e;
    if (dumpValid && dumpReady) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $error("FAIL sb_underflow: observed=beat expected=none");
      end else begin
        e = sb.pop_front();
        chk("dump_addr", {27'd0, dumpAddr}, {27'd0, e.addr});
        chk("dump_data", dumpData, e.data);
      end
    end
    tick();
  endtask

  initial begin
    logic [31:0] byp_exp;
    for (int r = 0; r < 32; r++) mdl[r] = '0;
    Reset_n   = 1'b0;
    readReg1  = 5'd21;
    readReg2  = 5'd10;
    regWrite  = 1'b0;
    writeReg  = '0;
    writeData = '0;
    writeStrb = '0;
    dumpStart = 1'b0;
    dumpReady = 1'b1;
    #1;
    chk("rst_rd1", readData1, 32'h0);
    chk("rst_rd2", readData2, 32'h0);
    chk("rst_busy", {31'd0, dumpBusy}, 32'd0);
    chk("rst_valid", {31'd0, dumpValid}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();

    wr(5'd21, 32'hFFFF0000, 4'hF);
    wr(5'd10, 32'h0000FFFF, 4'hF);
    chk("full_r21", readData1, 32'hFFFF0000);
    chk("full_r10", readData2, 32'h0000FFFF);
    wr(5'd0, 32'h12345678, 4'hF);
    readReg1 = 5'd0;
    #1;
    chk("zero_r0", readData1, 32'h0);

    readReg1  = 5'd5;
    regWrite  = 1'b1;
    writeReg  = 5'd5;
    writeData = 32'hDEADBEEF;
    writeStrb = 4'hF;
    #1;
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'hDEADBEEF;
`else
    byp_exp = 32'h0;
`endif
    chk("bypass_r5", readData1, byp_exp);
    tick();
    regWrite = 1'b0;
    mdl[5]   = 32'hDEADBEEF;
    chk("after_r5", readData1, 32'hDEADBEEF);

    readReg1  = 5'd0;
    regWrite  = 1'b1;
    writeReg  = 5'd0;
    writeData = 32'hFFFFFFFF;
    #1;
    chk("bypass_r0", readData1, 32'h0);
    tick();
    regWrite = 1'b0;
    chk("after_r0", readData1, 32'h0);

    dumpReady = 1'b1;
    dumpStart = 1'b1;
    push_dump();
    tick();
    busy_cnt = 0;
    g = 0;
    while (dumpBusy && g < 100) begin
      busy_cnt++;
      dump_step();
      g++;
    end
    dumpStart = 1'b0;
    chk("dump_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("dump_sb_empty", 32'(sb.size()), 32'd0);
    chk("dump_end_valid", {31'd0, dumpValid}, 32'd0);
    tick();
    chk("no_restart", {31'd0, dumpBusy}, 32'd0);

    readReg1 = 5'd21;
    wr(5'd21, 32'h000000AB, 4'h1);
    chk("strb_r21", readData1, 32'hFFFF00AB);
    wr(5'd21, 32'hFFFF0000, 4'hF);
    chk("restore_r21", readData1, 32'hFFFF0000);

    dumpStart = 1'b1;
    push_dump();
    tick();
    dumpStart = 1'b0;
    g = 0;
    while (!(dumpValid && dumpAddr == 5'd21) && g < 64) begin
      dump_step();
      g++;
    end
    chk("reach_beat21", {31'd0, dumpValid}, 32'd1);
    dumpReady = 1'b0;
    wr(5'd21, 32'h00000001, 4'hF);
    for (int k = 0; k < 3; k++) begin
      chk("stall_addr", {27'd0, dumpAddr}, 32'd21);
      chk("stall_data", dumpData, 32'hFFFF0000);
      tick();
    end
    chk("stall_r21_read", readData1, 32'h00000001);
    dumpReady = 1'b1;
    g = 0;
    while (!(dumpValid && dumpAddr == 5'd25) && g < 64) begin
      dump_step();
      g++;
    end
    chk("reach_beat25", {31'd0, dumpValid}, 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, dumpValid}, 32'd0);
    chk("abort_busy", {31'd0, dumpBusy}, 32'd0);
    chk("abort_addr", {27'd0, dumpAddr}, 32'd0);
    chk("abort_data", dumpData, 32'h0);
    sb.delete();
    for (int r = 0; r < 32; r++) mdl[r] = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_valid", {31'd0, dumpValid}, 32'd0);
    end
    chk("post_rst_r21", readData1, 32'h0);
    chk("post_rst_r10", readData2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
